// File: rtl/atm.sv
// Single-account ATM transaction controller.
// Latency: one cycle; every input is sampled on the rising clk edge and its result appears after that edge.
// Backpressure: none. The block accepts one evaluation per cycle and a held operation repeats every cycle.
//
// Ports:
//   clk, reset             - clock and synchronous active-high reset
//   operation[1:0]         - 00 enquiry, 01 deposit, 10 withdraw, 11 reserved
//   amount[15:0]           - unsigned transaction amount
//   pin, correct_pin[3:0]  - entered and reference PIN
//   balance[15:0]          - registered account balance
//   access_granted         - registered: last cycle had a correct PIN while unlocked
//   transaction_successful - registered: last cycle completed an operation
module atm #(
  parameter logic [15:0] INIT_BALANCE = 16'd1000,
  parameter int          MAX_ATTEMPTS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  operation,
  input  logic [15:0] amount,
  input  logic [3:0]  pin,
  input  logic [3:0]  correct_pin,
  output logic [15:0] balance,
  output logic        access_granted,
  output logic        transaction_successful
);

  typedef enum logic {
    ST_ACTIVE = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam logic [1:0] OP_ENQUIRY  = 2'b00;
  localparam logic [1:0] OP_DEPOSIT  = 2'b01;
  localparam logic [1:0] OP_WITHDRAW = 2'b10;

  localparam logic [3:0] MAX_CNT = 4'(MAX_ATTEMPTS);

  state_t      state_q, state_d;
  logic [3:0]  attempts_q, attempts_d;
  logic [15:0] balance_q, balance_d;
  logic        granted_q, granted_d;
  logic        success_q, success_d;

  // Bit 16 of the widened sum flags a deposit that would overflow the balance.
  logic [16:0] dep_sum;
  logic [3:0]  attempts_inc;

  assign dep_sum      = {1'b0, balance_q} + {1'b0, amount};
  assign attempts_inc = attempts_q + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_ACTIVE;
      attempts_q <= 4'd0;
      balance_q  <= INIT_BALANCE;
      granted_q  <= 1'b0;
      success_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      attempts_q <= attempts_d;
      balance_q  <= balance_d;
      granted_q  <= granted_d;
      success_q  <= success_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    attempts_d = attempts_q;
    balance_d  = balance_q;
    granted_d  = 1'b0;
    success_d  = 1'b0;

    case (state_q)
      ST_ACTIVE: begin
        if (pin != correct_pin) begin
          attempts_d = attempts_inc;
          if (attempts_inc >= MAX_CNT) begin
            state_d = ST_LOCKED;
          end
        end else begin
          granted_d  = 1'b1;
          attempts_d = 4'd0;
          // amount is only consulted inside the deposit/withdraw branches, so an
          // undefined amount on other cycles can never reach the balance.
          case (operation)
            OP_ENQUIRY: begin
              success_d = 1'b1;
            end
            OP_DEPOSIT: begin
              if (!dep_sum[16]) begin
                balance_d = dep_sum[15:0];
                success_d = 1'b1;
              end
            end
            OP_WITHDRAW: begin
              if (amount <= balance_q) begin
                balance_d = balance_q - amount;
                success_d = 1'b1;
              end
            end
            default: begin
              success_d = 1'b0;
            end
          endcase
        end
      end
      // Locked: everything frozen until reset.
      default: begin
        state_d = ST_LOCKED;
      end
    endcase
  end

  assign balance                = balance_q;
  assign access_granted         = granted_q;
  assign transaction_successful = success_q;

endmodule

// File: tb/tb_atm.sv
// Directed self-checking bench for atm.
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
// Every expected value is hand-computed from the account behaviour.
module tb_atm;

  logic        clk;
  logic        reset;
  logic [1:0]  operation;
  logic [15:0] amount;
  logic [3:0]  pin;
  logic [3:0]  correct_pin;
  logic [15:0] balance;
  logic        access_granted;
  logic        transaction_successful;

  int checks;
  int errors;

  localparam logic [3:0] GOOD = 4'b1111;
  localparam logic [3:0] BAD  = 4'b1010;

  atm #(
    .INIT_BALANCE(16'd1000),
    .MAX_ATTEMPTS(3)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .operation              (operation),
    .amount                 (amount),
    .pin                    (pin),
    .correct_pin            (correct_pin),
    .balance                (balance),
    .access_granted         (access_granted),
    .transaction_successful (transaction_successful)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs, let one rising edge pass, then settle.
  task automatic step(input logic rst, input logic [1:0] op, input logic [15:0] amt,
                      input logic [3:0] p);
    reset     = rst;
    operation = op;
    amount    = amt;
    pin       = p;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] exp_bal, input logic exp_gr,
                     input logic exp_ok);
    checks++;
    assert (balance === exp_bal) else begin
      errors++;
      $error("FAIL %s balance: got %0d expected %0d", tag, balance, exp_bal);
    end
    checks++;
    assert (access_granted === exp_gr) else begin
      errors++;
      $error("FAIL %s access_granted: got %b expected %b", tag, access_granted, exp_gr);
    end
    checks++;
    assert (transaction_successful === exp_ok) else begin
      errors++;
      $error("FAIL %s success: got %b expected %b", tag, transaction_successful, exp_ok);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    correct_pin = GOOD;
    reset       = 1'b1;
    operation   = 2'b00;
    amount      = 16'd0;
    pin         = 4'd0;
    #1;

    step(1'b1, 2'b00, 16'd0, BAD);         chk("reset",          16'd1000, 1'b0, 1'b0);
    step(1'b0, 2'b00, 16'd0, BAD);         chk("wrong_pin",      16'd1000, 1'b0, 1'b0);
    step(1'b0, 2'b00, 16'd0, GOOD);        chk("enquiry",        16'd1000, 1'b1, 1'b1);
    step(1'b0, 2'b01, 16'd500, GOOD);      chk("dep500",         16'd1500, 1'b1, 1'b1);
    step(1'b0, 2'b10, 16'd300, GOOD);      chk("wd300",          16'd1200, 1'b1, 1'b1);
    step(1'b0, 2'b10, 16'd2000, GOOD);     chk("wd_insufficient",16'd1200, 1'b1, 1'b0);
    step(1'b0, 2'b10, 16'd1200, GOOD);     chk("wd_exact",       16'd0,    1'b1, 1'b1);
    step(1'b0, 2'b01, 16'd1, GOOD);        chk("dep1",           16'd1,    1'b1, 1'b1);
    step(1'b0, 2'b01, 16'd65535, GOOD);    chk("dep_overflow",   16'd1,    1'b1, 1'b0);
    step(1'b0, 2'b01, 16'd65534, GOOD);    chk("dep_to_max",     16'd65535,1'b1, 1'b1);
    step(1'b0, 2'b01, 16'd0, GOOD);        chk("dep0",           16'd65535,1'b1, 1'b1);
    step(1'b0, 2'b10, 16'd0, GOOD);        chk("wd0",            16'd65535,1'b1, 1'b1);
    step(1'b0, 2'b11, 16'd5, GOOD);        chk("reserved_op",    16'd65535,1'b1, 1'b0);
    step(1'b0, 2'b00, 16'hxxxx, GOOD);     chk("enq_x_amount",   16'd65535,1'b1, 1'b1);
    step(1'b0, 2'b10, 16'd65535, GOOD);    chk("wd_all",         16'd0,    1'b1, 1'b1);

    // Three consecutive wrong PINs lock the account.
    step(1'b0, 2'b01, 16'hxxxx, BAD);      chk("bad1_x_amount",  16'd0,    1'b0, 1'b0);
    step(1'b0, 2'b01, 16'd100, 4'b0000);   chk("bad2",           16'd0,    1'b0, 1'b0);
    step(1'b0, 2'b01, 16'd100, BAD);       chk("bad3",           16'd0,    1'b0, 1'b0);
    step(1'b0, 2'b01, 16'd100, GOOD);      chk("locked_dep",     16'd0,    1'b0, 1'b0);
    step(1'b0, 2'b00, 16'd0, GOOD);        chk("locked_enq",     16'd0,    1'b0, 1'b0);

    // Reset unlocks and reloads the balance.
    step(1'b1, 2'b01, 16'd100, GOOD);      chk("reset_unlock",   16'd1000, 1'b0, 1'b0);
    step(1'b0, 2'b00, 16'd0, GOOD);        chk("after_reset",    16'd1000, 1'b1, 1'b1);

    // A correct PIN between wrong ones clears the attempt counter.
    step(1'b0, 2'b00, 16'd0, BAD);         chk("w1",             16'd1000, 1'b0, 1'b0);
    step(1'b0, 2'b00, 16'd0, BAD);         chk("w2",             16'd1000, 1'b0, 1'b0);
    step(1'b0, 2'b00, 16'd0, GOOD);        chk("c1",             16'd1000, 1'b1, 1'b1);
    step(1'b0, 2'b00, 16'd0, BAD);         chk("w3",             16'd1000, 1'b0, 1'b0);
    step(1'b0, 2'b00, 16'd0, BAD);         chk("w4",             16'd1000, 1'b0, 1'b0);
    step(1'b0, 2'b01, 16'd100, GOOD);      chk("not_locked",     16'd1100, 1'b1, 1'b1);
    step(1'b0, 2'b01, 16'd100, GOOD);      chk("held_dep",       16'd1200, 1'b1, 1'b1);
    step(1'b1, 2'b01, 16'd100, GOOD);      chk("reset_mid_dep",  16'd1000, 1'b0, 1'b0);
    step(1'b0, 2'b01, 16'd100, GOOD);      chk("dep_after_rst",  16'd1100, 1'b1, 1'b1);

    // Exactly MAX_ATTEMPTS wrong PINs after a grant: two are not enough, the third locks.
    step(1'b0, 2'b00, 16'd0, BAD);         chk("l1",             16'd1100, 1'b0, 1'b0);
    step(1'b0, 2'b00, 16'd0, BAD);         chk("l2",             16'd1100, 1'b0, 1'b0);
    step(1'b0, 2'b10, 16'd100, GOOD);      chk("l2_then_good",   16'd1000, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
